// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit path between NUM_REQ byte sources. Pending
//   requests are served round-robin, one byte per frame. After issuing a byte
//   the arbiter waits for the transmitter's end-of-frame pulse. A watchdog
//   returns it to idle if that pulse never arrives.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   req          level request per source, held until the matching ack
//   req_data     byte of source i at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse: byte of source i accepted
//   tx_start     one-cycle pulse to the transmitter: start a frame
//   tx_data      byte to send, held from tx_start until the return to idle
//   tx_done      one-cycle end-of-frame pulse from the transmitter
//   busy         high while a frame is being issued or awaited
//   grant_id     index of the source currently or last served
//   timeout_err  one-cycle pulse when the watchdog aborts a frame
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  // A disabled watchdog still needs a legal (1-bit) counter width.
  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [WD_W-1:0]     wd_cnt_reg, wd_cnt_next;
  logic [ID_W-1:0]     grant_id_reg, grant_id_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic                tx_start_reg, tx_start_next;
  logic                busy_reg, busy_next;
  logic                timeout_err_reg, timeout_err_next;

  // Unpack the flat data bus into one byte per source.
  logic [DATA_W-1:0] req_data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: first set request starting at rr_ptr, wrapping mod NUM_REQ.
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  always_comb begin
    logic [ID_W:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_reg} + (ID_W + 1)'(i);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      if (!pick_found && req[sum[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    wd_cnt_next      = wd_cnt_reg;
    grant_id_next    = grant_id_reg;
    tx_data_next     = tx_data_reg;
    ack_next         = '0;
    tx_start_next    = 1'b0;
    timeout_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // tx_done here is a stray pulse and is ignored.
        if (pick_found) begin
          grant_id_next = pick_idx;
          tx_data_next  = req_data_arr[pick_idx];
          // ack and tx_start are registered, so they are high during ISSUE.
          ack_next      = NUM_REQ'(1) << pick_idx;
          tx_start_next = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_next = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + ID_W'(1);
        wd_cnt_next = '0;
        state_next  = WAIT;
      end
      WAIT: begin
        // tx_done takes priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          state_next = IDLE;
        end else if (TIMEOUT_CYC != 0 && wd_cnt_reg == WD_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else if (wd_cnt_reg != {WD_W{1'b1}}) begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      wd_cnt_reg      <= '0;
      grant_id_reg    <= '0;
      tx_data_reg     <= '0;
      ack_reg         <= '0;
      tx_start_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      wd_cnt_reg      <= wd_cnt_next;
      grant_id_reg    <= grant_id_next;
      tx_data_reg     <= tx_data_next;
      ack_reg         <= ack_next;
      tx_start_reg    <= tx_start_next;
      busy_reg        <= busy_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign ack         = ack_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign busy        = busy_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (4 sources, 8-bit data, 100-cycle
//   watchdog). Expected values are hand-derived from the cycle timing.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TMO     = 100;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [1:0]                grant_id;
  logic                      timeout_err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'h0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  initial begin
    logic [7:0] bytes [NUM_REQ];
    int         order [5];
    int         fails_tx_start;

    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    order = '{0, 1, 2, 3, 0};

    // ---------------- reset state ----------------
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    #1;
    check_all_zero("rst0");
    tick();
    rst = 1'b0;

    // ---------------- 1: single request ----------------
    req_data[2*8 +: 8] = 8'hA5;
    req = 4'b0100;
    tick();
    chk("t1_tx_start", 32'(tx_start), 32'h1);
    chk("t1_ack", 32'(ack), 32'h4);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_grant", 32'(grant_id), 32'h2);
    chk("t1_busy_issue", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_tx_start_wait", 32'(tx_start), 32'h0);
    chk("t1_ack_wait", 32'(ack), 32'h0);
    chk("t1_busy_wait", 32'(busy), 32'h1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t1_busy_after_done", 32'(busy), 32'h0);
    chk("t1_tx_data_hold", 32'(tx_data), 32'hA5);
    $display("txn t1: grant=%0d data=0x%0h", grant_id, tx_data);

    // ---------------- 2: all requesting, round-robin ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*8 +: 8] = bytes[i];
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      tick();
      chk($sformatf("t2_f%0d_tx_start", f), 32'(tx_start), 32'h1);
      chk($sformatf("t2_f%0d_grant", f), 32'(grant_id), 32'(order[f]));
      chk($sformatf("t2_f%0d_ack", f), 32'(ack), 32'(1) << order[f]);
      chk($sformatf("t2_f%0d_data", f), 32'(tx_data), 32'(bytes[order[f]]));
      $display("txn t2 frame %0d: grant=%0d ack=%b data=0x%0h", f, grant_id, ack, tx_data);
      tick();
      chk($sformatf("t2_f%0d_ack_clear", f), 32'(ack), 32'h0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    req = 4'b0000;

    // ---------------- 3: request raised while busy ----------------
    req = 4'b0001;
    tick();
    chk("t3_grant0", 32'(grant_id), 32'h0);
    chk("t3_start0", 32'(tx_start), 32'h1);
    req = 4'b0010;
    fails_tx_start = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t3_no_start_c%0d", c), 32'(tx_start), 32'h0);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t3_busy_low", 32'(busy), 32'h0);
    chk("t3_no_start_idle", 32'(tx_start), 32'h0);
    tick();
    chk("t3_start1", 32'(tx_start), 32'h1);
    chk("t3_grant1", 32'(grant_id), 32'h1);
    chk("t3_data1", 32'(tx_data), 32'h22);
    $display("txn t3: grant=%0d data=0x%0h", grant_id, tx_data);
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // ---------------- 4: watchdog expiry ----------------
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();  // now in WAIT, counter at 0
    for (int c = 1; c < TMO; c++) begin
      tick();
      if (timeout_err !== 1'b0) fails_tx_start++;
    end
    chk("t4_no_early_timeout", 32'(fails_tx_start), 32'h0);
    chk("t4_busy_before", 32'(busy), 32'h1);
    tick();
    chk("t4_timeout_pulse", 32'(timeout_err), 32'h1);
    chk("t4_busy_after", 32'(busy), 32'h0);
    $display("txn t4: timeout_err=%0d busy=%0d", timeout_err, busy);
    tick();
    chk("t4_timeout_clear", 32'(timeout_err), 32'h0);
    req = 4'b1000;
    tick();
    chk("t4_next_start", 32'(tx_start), 32'h1);
    chk("t4_next_grant", 32'(grant_id), 32'h3);
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // ---------------- 6: tx_done coincident with watchdog expiry ----------------
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();  // WAIT, counter 0
    for (int c = 1; c < TMO; c++) tick();
    tx_done = 1'b1;  // counter now at TMO-1
    tick();
    tx_done = 1'b0;
    chk("t6_no_timeout", 32'(timeout_err), 32'h0);
    chk("t6_idle", 32'(busy), 32'h0);
    tick();
    chk("t6_no_timeout_late", 32'(timeout_err), 32'h0);
    $display("txn t6: timeout_err=%0d busy=%0d", timeout_err, busy);

    // ---------------- 5: asynchronous reset in WAIT ----------------
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    tick();
    chk("t5_busy_pre", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_start", 32'(tx_start), 32'h1);
    chk("t5_grant", 32'(grant_id), 32'h1);
    chk("t5_ack", 32'(ack), 32'h2);
    $display("txn t5: grant=%0d ack=%b", grant_id, ack);
    req = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
